// File: rtl/pipelined_adder_nbit.sv
// Pipelined N-bit adder with a valid/ready streaming interface.
// The carry chain is cut into NUM_STAGES equal slices. Stage k adds slice k
// with the carry registered by stage k-1. Upper operand slices are delayed
// (skewed) so they reach their stage together with their carry. Lower result
// slices are delayed (deskewed) so the full sum reaches the output aligned.
// A single global enable stalls every register whenever the output is held.
//
// Parameters:
//   NUM_BITS   operand/sum width, a multiple of NUM_STAGES
//   NUM_STAGES pipeline depth, 1..NUM_BITS
//   SIGNED_OVF 0: overflow = carry out of MSB, 1: two's-complement overflow
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready depends on out_* only)
//   a, b, carry_in      operands and carry into bit 0
//   out_valid/out_ready result handshake
//   sum, overflow       registered result, held while stalled
module pipelined_adder_nbit #(
  parameter int unsigned NUM_BITS   = 16,
  parameter int unsigned NUM_STAGES = 4,
  parameter bit          SIGNED_OVF = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow
);

  localparam int unsigned SLICE = NUM_BITS / NUM_STAGES;
  localparam int unsigned LAST  = NUM_STAGES - 1;

  logic                  en;
  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_d;
  logic [NUM_STAGES-1:0] carry_q;
  logic [NUM_STAGES-1:0] carry_d;

  // Global stall: everything advances unless a result is waiting unaccepted.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = valid_q[LAST];
  // The last stage's carry register holds the selected overflow flavour.
  assign overflow  = carry_q[LAST];

  // Per-stage valid and carry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
    end else if (en) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int unsigned LEAD  = k;
    localparam int unsigned DEPTH = NUM_STAGES - k;

    logic [SLICE-1:0] op_a;
    logic [SLICE-1:0] op_b;
    logic [SLICE-1:0] slice_sum;
    logic             c_in;
    logic             slice_cout;
    logic [SLICE-1:0] res_q [DEPTH];

    if (k == 0) begin : g_head
      // First slice comes straight from the ports.
      assign op_a       = a[SLICE-1:0];
      assign op_b       = b[SLICE-1:0];
      assign c_in       = carry_in;
      assign valid_d[0] = in_valid;
    end else begin : g_skew
      logic [SLICE-1:0] skew_a [LEAD];
      logic [SLICE-1:0] skew_b [LEAD];

      // Delay this slice's operands by k cycles to meet its carry.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < LEAD; i++) begin
            skew_a[i] <= '0;
            skew_b[i] <= '0;
          end
        end else if (en) begin
          skew_a[0] <= a[k*SLICE +: SLICE];
          skew_b[0] <= b[k*SLICE +: SLICE];
          for (int unsigned i = 1; i < LEAD; i++) begin
            skew_a[i] <= skew_a[i-1];
            skew_b[i] <= skew_b[i-1];
          end
        end
      end

      assign op_a       = skew_a[LEAD-1];
      assign op_b       = skew_b[LEAD-1];
      assign c_in       = carry_q[k-1];
      assign valid_d[k] = valid_q[k-1];
    end

    // Slice adder.
    assign {slice_cout, slice_sum} = {1'b0, op_a} + {1'b0, op_b} + {{SLICE{1'b0}}, c_in};

    if (k == LAST && SIGNED_OVF) begin : g_sovf
      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      assign carry_d[k] = slice_cout ^ (op_a[SLICE-1] ^ op_b[SLICE-1] ^ slice_sum[SLICE-1]);
    end else begin : g_cout
      assign carry_d[k] = slice_cout;
    end

    // Result slice plus deskew delay up to the output stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          res_q[i] <= '0;
        end
      end else if (en) begin
        res_q[0] <= slice_sum;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          res_q[i] <= res_q[i-1];
        end
      end
    end

    assign sum[k*SLICE +: SLICE] = res_q[DEPTH-1];
  end

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Bench for pipelined_adder_nbit: five parameter sets, one active at a time.
// Driver pushes expected {overflow, sum} into a queue on every accepted
// operand; a negedge monitor compares every presented output to the queue
// head (so held values during stalls are checked too) and pops on transfer.
module tb_pipelined_adder_nbit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        cin_v;
  logic [31:0] a_v;
  logic [31:0] b_v;
  logic [4:0]  ir;
  logic [4:0]  ov;
  logic [4:0]  of;
  logic [15:0] sum0;
  logic [15:0] sum1;
  logic [7:0]  sum2;
  logic [15:0] sum3;
  logic [31:0] sum4;

  logic [2:0]  cur;
  logic        c_valid;
  logic        c_ready;
  logic [31:0] c_sum;
  logic [32:0] c_res;
  logic [32:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  bit          mon_on = 1'b0;
  bit          ready_mode = 1'b0;

  // inst 0: 16/4 unsigned, 1: 16/4 signed, 2: 8/1, 3: 16/16, 4: 32/4
  pipelined_adder_nbit #(.NUM_BITS(16), .NUM_STAGES(4), .SIGNED_OVF(1'b0)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a_v[15:0]), .b(b_v[15:0]),
    .carry_in(cin_v), .out_valid(ov[0]), .out_ready(out_ready), .sum(sum0), .overflow(of[0]));
  pipelined_adder_nbit #(.NUM_BITS(16), .NUM_STAGES(4), .SIGNED_OVF(1'b1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a_v[15:0]), .b(b_v[15:0]),
    .carry_in(cin_v), .out_valid(ov[1]), .out_ready(out_ready), .sum(sum1), .overflow(of[1]));
  pipelined_adder_nbit #(.NUM_BITS(8), .NUM_STAGES(1), .SIGNED_OVF(1'b0)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a_v[7:0]), .b(b_v[7:0]),
    .carry_in(cin_v), .out_valid(ov[2]), .out_ready(out_ready), .sum(sum2), .overflow(of[2]));
  pipelined_adder_nbit #(.NUM_BITS(16), .NUM_STAGES(16), .SIGNED_OVF(1'b0)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .a(a_v[15:0]), .b(b_v[15:0]),
    .carry_in(cin_v), .out_valid(ov[3]), .out_ready(out_ready), .sum(sum3), .overflow(of[3]));
  pipelined_adder_nbit #(.NUM_BITS(32), .NUM_STAGES(4), .SIGNED_OVF(1'b0)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[4]), .a(a_v), .b(b_v),
    .carry_in(cin_v), .out_valid(ov[4]), .out_ready(out_ready), .sum(sum4), .overflow(of[4]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // View of the instance currently under test.
  always_comb begin
    case (cur)
      3'd0:    c_sum = 32'(sum0);
      3'd1:    c_sum = 32'(sum1);
      3'd2:    c_sum = 32'(sum2);
      3'd3:    c_sum = 32'(sum3);
      default: c_sum = sum4;
    endcase
    c_valid = ov[cur];
    c_ready = ir[cur];
    c_res   = {of[cur], c_sum};
  end

  // Consumer: always ready, or pseudo-random backpressure.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: handshake rule and scoreboard comparison.
  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      if (c_ready !== (!c_valid || out_ready)) begin
        bad++;
        $display("FAIL in_ready_rule inst=%0d got=%b want=%b", cur, c_ready, !c_valid || out_ready);
      end
      if (c_valid !== 1'b0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output inst=%0d got=%h want=none", cur, c_res);
        end else begin
          if (c_res !== exp_q[0]) begin
            bad++;
            $display("FAIL result inst=%0d got=%h want=%h", cur, c_res, exp_q[0]);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [32:0] model(input logic [2:0] idx, input logic [31:0] av,
                                        input logic [31:0] bv, input logic c);
    int unsigned nb;
    logic [63:0] mask;
    logic [63:0] full;
    logic [63:0] s;
    logic        sa, sb, ss, ovf;
    case (idx)
      3'd2:    nb = 8;
      3'd4:    nb = 32;
      default: nb = 16;
    endcase
    mask = (64'd1 << nb) - 64'd1;
    full = (64'(av) & mask) + (64'(bv) & mask) + 64'(c);
    s    = full & mask;
    sa   = 1'(64'(av) >> (nb - 1));
    sb   = 1'(64'(bv) >> (nb - 1));
    ss   = 1'(s >> (nb - 1));
    if (idx == 3'd1) ovf = (sa == sb) && (ss != sa);
    else             ovf = 1'(full >> nb);
    return {ovf, s[31:0]};
  endfunction

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h want=%h", name, cur, got, want);
    end
  endtask

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic c,
                      input logic [32:0] expv, input bit push);
    int waited = 0;
    a_v      = av;
    b_v      = bv;
    cin_v    = c;
    in_valid = 1'b1;
    @(negedge clk);
    while (!c_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!c_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout inst=%0d got=in_ready_low want=accept", cur);
    end else if (push) begin
      exp_q.push_back(expv);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout inst=%0d got=%0d_pending want=0", cur, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic stream20();
    logic [31:0] av, bv;
    logic        c;
    ready_mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      av = $urandom;
      bv = $urandom;
      c  = 1'($urandom_range(0, 1));
      send(av, bv, c, model(cur, av, bv, c), 1'b1);
    end
    drain();
    ready_mode = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog inst=%0d got=timeout want=finish", cur);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    cur      = 3'd0;
    rst      = 1'b1;
    in_valid = 1'b1;
    a_v      = 32'hAAAA_5555;
    b_v      = 32'h1234_4321;
    cin_v    = 1'b1;

    // Reset with in_valid high: nothing valid, outputs zero.
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    @(negedge clk);
    check("rst_valid_1", 33'(c_valid), 33'd0);
    check("rst_out_1", c_res, 33'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_valid_2", 33'(c_valid), 33'd0);
    check("rst_out_2", c_res, 33'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 33'(c_ready), 33'd1);
    @(posedge clk);
    #1;

    // Full-width carry ripple and latency.
    send(32'h0FFF, 32'h0000, 1'b1, 33'h0_0000_1000, 1'b1);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (c_valid) break;
      @(posedge clk);
      lat++;
    end
    check("latency", 33'(lat), 33'd3);
    drain();

    // Unsigned wrap and plain add.
    send(32'hFFFF, 32'h0001, 1'b0, 33'h1_0000_0000, 1'b1);
    send(32'h1111, 32'h1111, 1'b0, 33'h0_0000_2222, 1'b1);
    drain();
    stream20();

    // Reset with three operands in flight: none may appear.
    send(32'h0001, 32'h0002, 1'b0, 33'd0, 1'b0);
    send(32'h0003, 32'h0004, 1'b0, 33'd0, 1'b0);
    send(32'h0005, 32'h0006, 1'b1, 33'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (c_valid) seen++;
    end
    check("midflight_outputs", 33'(seen), 33'd0);

    // Signed overflow instance.
    do_reset();
    cur = 3'd1;
    send(32'h7FFF, 32'h0001, 1'b0, 33'h1_0000_8000, 1'b1);
    send(32'hFFFF, 32'h0001, 1'b0, 33'h0_0000_0000, 1'b1);
    send(32'h8000, 32'hFFFF, 1'b0, 33'h1_0000_7FFF, 1'b1);
    drain();
    stream20();

    // 8/1: single registered adder.
    do_reset();
    cur = 3'd2;
    send(32'h00FF, 32'h0001, 1'b0, 33'h1_0000_0000, 1'b1);
    send(32'h0012, 32'h0034, 1'b1, 33'h0_0000_0047, 1'b1);
    drain();
    stream20();

    // 16/16: one bit per stage.
    do_reset();
    cur = 3'd3;
    send(32'h8000, 32'h8000, 1'b0, 33'h1_0000_0000, 1'b1);
    send(32'h7FFF, 32'h0000, 1'b1, 33'h0_0000_8000, 1'b1);
    drain();
    stream20();

    // 32/4: wide operands.
    do_reset();
    cur = 3'd4;
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000, 1'b1);
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789, 1'b1);
    drain();
    stream20();

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
